// File: rtl/redmule_pkg.sv
// RedMulE shared types: wide TCDM port request/response bundles
// and the response-pipeline stage record used by the TCDM responder.
package redmule_pkg;

  localparam int unsigned DATA_W = 544;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned USER_W = 8;
  localparam int unsigned TCDM_RESP_MAX_LAT = 4;

  typedef struct packed {
    logic              req;
    logic              wen;
    logic [BE_W-1:0]   be;
    logic [3:0]        boffs;
    logic [ADDR_W-1:0] add;
    logic [DATA_W-1:0] data;
    logic              lrdy;
    logic [USER_W-1:0] user;
  } redmule_default_data_req_t;

  typedef struct packed {
    logic              gnt;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_opc;
    logic [USER_W-1:0] r_user;
  } redmule_default_data_rsp_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              opc;
    logic [USER_W-1:0] user;
  } tcdm_resp_stage_t;

endpackage

// File: rtl/redmule_tcdm_resp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) driving random grant stalls.
// Reloads its seed on reset and on clear.
module redmule_tcdm_resp_lfsr #(
  parameter logic [15:0] Seed = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic        fb;

  assign fb = lfsr_q[15] ^ lfsr_q[13]
            ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= Seed;
    end else if (clear_i) begin
      lfsr_q <= Seed;
    end else if (en_i) begin
      lfsr_q <= {lfsr_q[14:0], fb};
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Wide-port TCDM responder: word-addressed scratchpad, fixed-latency stallable
// read pipeline. Define REDMULE_TCDM_RESP_STALL_EN for random grant stalls.
module redmule_tcdm_responder
  import redmule_pkg::*;
#(
  parameter int unsigned DataW       = DATA_W,
  parameter int unsigned NumLanes    = DataW / 32,
  parameter int unsigned NumWords    = 4096,
  parameter logic [31:0] BaseAddr    = 32'h0,
  parameter int unsigned ReadLatency = 1,
  parameter logic [15:0] LfsrSeed    = 16'hACE1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  redmule_default_data_req_t req_i,
  output redmule_default_data_rsp_t rsp_o
);

  localparam int unsigned IdxW = $clog2(NumWords);
  localparam int unsigned Last = ReadLatency - 1;

  if (DataW != DATA_W || NumLanes * 32 != DataW) begin : g_bad_width
    $error("DataW must equal DATA_W and NumLanes*32");
  end
  if (ReadLatency < 1 || ReadLatency > TCDM_RESP_MAX_LAT) begin : g_bad_lat
    $error("ReadLatency out of range");
  end

  logic [NumWords-1:0][31:0] mem_q;
  tcdm_resp_stage_t          pipe_q [ReadLatency];
  tcdm_resp_stage_t          stage_in;

  logic [31:0]      off;
  logic [31:0]      base;
  logic             in_range;
  logic [IdxW-1:0]  lane_idx [NumLanes];
  logic [DataW-1:0] rd_data;

  logic freeze;
  logic stall_ok;
  logic gnt;
  logic rd_gnt;
  logic wr_gnt;

  assign off = req_i.add - BaseAddr;
  assign base = {2'b00, off[31:2]};
  assign in_range = (req_i.add >= BaseAddr)
                 && (base < 32'(NumWords));

  // base < NumWords when in range, so one conditional subtract wraps.
  for (genvar i = 0; i < NumLanes; i++) begin : g_lane
    logic [IdxW:0] sum;
    assign sum = base[IdxW:0] + (IdxW+1)'(i);
    assign lane_idx[i] = IdxW'(
      sum >= (IdxW+1)'(NumWords)
        ? sum - (IdxW+1)'(NumWords)
        : sum);
    assign rd_data[32*i +: 32] =
      in_range ? mem_q[lane_idx[i]] : 32'h0;
  end

`ifdef REDMULE_TCDM_RESP_STALL_EN
  logic [15:0] lfsr;
  logic        unused_ok;

  redmule_tcdm_resp_lfsr #(
    .Seed    (LfsrSeed)
  ) i_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  assign stall_ok = lfsr[1:0] != 2'b00;
  assign unused_ok = ^{req_i.boffs, off[1:0], lfsr[15:2]};
`else
  logic unused_ok;

  assign stall_ok = 1'b1;
  assign unused_ok = ^{req_i.boffs, off[1:0], LfsrSeed};
`endif

  assign freeze = pipe_q[Last].valid & ~req_i.lrdy;
  assign gnt = req_i.req & ~freeze & stall_ok;
  assign rd_gnt = gnt & req_i.wen & ~clear_i;
  assign wr_gnt = gnt & ~req_i.wen & in_range;

  assign stage_in = '{
    valid: 1'b1,
    data:  rd_data,
    opc:   ~in_range,
    user:  req_i.user
  };

  // Storage is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_gnt) begin
      for (int i = 0; i < NumLanes; i++) begin
        for (int k = 0; k < 4; k++) begin
          if (req_i.be[4*i+k]) begin
            mem_q[lane_idx[i]][8*k +: 8] <=
              req_i.data[32*i+8*k +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < ReadLatency; s++) begin
        pipe_q[s] <= '0;
      end
    end else if (clear_i) begin
      for (int s = 0; s < ReadLatency; s++) begin
        pipe_q[s].valid <= 1'b0;
      end
    end else if (!freeze) begin
      if (rd_gnt) begin
        pipe_q[0] <= stage_in;
      end else begin
        pipe_q[0].valid <= 1'b0;
      end
      for (int s = 1; s < ReadLatency; s++) begin
        if (pipe_q[s-1].valid) begin
          pipe_q[s] <= pipe_q[s-1];
        end else begin
          pipe_q[s].valid <= 1'b0;
        end
      end
    end
  end

  assign rsp_o = '{
    gnt:     gnt,
    r_valid: pipe_q[Last].valid,
    r_data:  pipe_q[Last].data,
    r_opc:   pipe_q[Last].opc,
    r_user:  pipe_q[Last].user
  };

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Bench for redmule_tcdm_responder: queue-based response model checked
// every cycle, plus directed vectors with literal expectations.
module tb_redmule_tcdm_responder;
  import redmule_pkg::*;

  localparam int unsigned LAT = 3;
  localparam int unsigned NW = 4096;
  localparam int unsigned NL = DATA_W / 32;
  localparam logic [31:0] BASE = 32'h0001_0000;
`ifdef REDMULE_TCDM_RESP_STALL_EN
  localparam int NBURST = 1000;
`else
  localparam int NBURST = 200;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic clear = 1'b0;
  redmule_default_data_req_t req;
  redmule_default_data_rsp_t rsp;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rv_cnt = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
    logic              opc;
    logic [USER_W-1:0] user;
    int                cnt;
  } exp_t;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              opc;
    logic [USER_W-1:0] user;
    int                c;
  } ret_t;

  exp_t q[$];
  ret_t ret[$];
  logic [31:0] mm [NW];
  logic [3:0]  mk [NW];

  redmule_tcdm_responder #(
    .NumWords    (NW),
    .BaseAddr    (BASE),
    .ReadLatency (LAT)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .clear_i (clear),
    .req_i   (req),
    .rsp_o   (rsp)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name,
                     input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic oor(input logic [31:0] add);
    return (add < BASE) || (((add - BASE) >> 2) >= NW);
  endfunction

  function automatic exp_t model_read(input logic [31:0] add,
                                      input logic [USER_W-1:0] user);
    exp_t e;
    int unsigned b;
    int unsigned w;
    e.data = '0;
    e.mask = '0;
    e.user = user;
    e.cnt = LAT - 1;
    e.opc = oor(add);
    if (e.opc) begin
      e.mask = '1;
    end else begin
      b = (add - BASE) >> 2;
      for (int i = 0; i < NL; i++) begin
        w = (b + i) % NW;
        e.data[32*i +: 32] = mm[w];
        for (int k = 0; k < 4; k++)
          if (mk[w][k]) e.mask[32*i+8*k +: 8] = 8'hFF;
      end
    end
    return e;
  endfunction

  function automatic void model_write(input logic [31:0] add,
                                      input logic [DATA_W-1:0] data,
                                      input logic [BE_W-1:0] be);
    int unsigned b;
    int unsigned w;
    if (oor(add)) return;
    b = (add - BASE) >> 2;
    for (int i = 0; i < NL; i++) begin
      w = (b + i) % NW;
      for (int k = 0; k < 4; k++) begin
        if (be[4*i+k]) begin
          mm[w][8*k +: 8] = data[32*i+8*k +: 8];
          mk[w][k] = 1'b1;
        end
      end
    end
  endfunction

  // Per-cycle compare against the response queue.
  initial forever begin : cmp
    logic ev;
    logic eg;
    logic g;
    ret_t r;
    @(negedge clk);
    if (rsp.r_valid) rv_cnt++;
    if (!rst_ni) begin
      q.delete();
      chk("rst r_valid", DATA_W'(rsp.r_valid), '0);
    end else begin
      ev = (q.size() > 0) && (q[0].cnt == 0);
      eg = req.req & ~(ev & ~req.lrdy);
      chk("r_valid", DATA_W'(rsp.r_valid), DATA_W'(ev));
      if (ev) begin
        chk("r_data", rsp.r_data & q[0].mask, q[0].data & q[0].mask);
        chk("r_opc", DATA_W'(rsp.r_opc), DATA_W'(q[0].opc));
        chk("r_user", DATA_W'(rsp.r_user), DATA_W'(q[0].user));
      end
`ifdef REDMULE_TCDM_RESP_STALL_EN
      g = rsp.gnt;
      chk("gnt legal", DATA_W'(rsp.gnt & ~eg), '0);
`else
      g = eg;
      chk("gnt", DATA_W'(rsp.gnt), DATA_W'(eg));
`endif
      if (rsp.r_valid && req.lrdy) begin
        r.data = rsp.r_data;
        r.opc = rsp.r_opc;
        r.user = rsp.r_user;
        r.c = cyc;
        ret.push_back(r);
      end
      if (clear) begin
        q.delete();
      end else begin
        if (ev && req.lrdy) void'(q.pop_front());
        if (!(ev && !req.lrdy))
          foreach (q[j]) if (q[j].cnt > 0) q[j].cnt--;
        if (g && req.wen) q.push_back(model_read(req.add, req.user));
      end
      if (g && !req.wen) model_write(req.add, req.data, req.be);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] add,
                       input logic [DATA_W-1:0] data,
                       input logic [BE_W-1:0] be,
                       input logic [USER_W-1:0] user,
                       output int gc);
    int n;
    n = 0;
    gc = -1;
    req.req = 1'b1;
    req.wen = wen;
    req.add = add;
    req.data = data;
    req.be = be;
    req.user = user;
    while (gc < 0 && n < 200) begin
      @(negedge clk);
      if (rsp.gnt) gc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    req.req = 1'b0;
    if (gc < 0) begin
      total++;
      bad++;
      $display("FAIL issue: no gnt for add %h", add);
    end
  endtask

  task automatic wait_ret(input int n);
    int t;
    t = 0;
    while (ret.size() < n && t < 200) begin
      step(1);
      t++;
    end
    chk("resp count", DATA_W'(ret.size()), DATA_W'(n));
  endtask

  function automatic logic [DATA_W-1:0] lanes(input logic [31:0] b);
    logic [DATA_W-1:0] v;
    for (int i = 0; i < NL; i++) v[32*i +: 32] = b + i;
    return v;
  endfunction

  int g0, g1, g2, g3, gw, gr;
  int k, n, stalls, errs, snap;
  logic [DATA_W-1:0] ev_data;

  initial begin
    foreach (mk[i]) mk[i] = 4'h0;
    foreach (mm[i]) mm[i] = 32'h0;
    req = '0;
    req.lrdy = 1'b1;
    step(3);
    chk("reset r_valid", DATA_W'(rsp.r_valid), '0);
    chk("reset r_data", rsp.r_data, '0);
    chk("reset r_opc", DATA_W'(rsp.r_opc), '0);
    chk("reset r_user", DATA_W'(rsp.r_user), '0);
    rst_ni = 1'b1;
    step(2);

    // lane index pattern, read right after write
    ret.delete();
    issue(1'b0, BASE + 32'h100, lanes(32'h0), '1, 8'h00, gw);
    issue(1'b1, BASE + 32'h100, '0, '0, 8'h11, gr);
    wait_ret(1);
    chk("t1 lanes", ret[0].data, lanes(32'h0));
    chk("t1 opc", DATA_W'(ret[0].opc), '0);
    chk("t1 user", DATA_W'(ret[0].user), DATA_W'(8'h11));
    chk("t1 latency", DATA_W'(ret[0].c - gr), DATA_W'(LAT));

    // byte enables on lane 0
    ret.delete();
    issue(1'b0, BASE + 32'h100, '1, '1, 8'h00, gw);
    issue(1'b0, BASE + 32'h100, '0, BE_W'(5), 8'h00, gw);
    issue(1'b1, BASE + 32'h100, '0, '0, 8'h22, gr);
    wait_ret(1);
    ev_data = '1;
    ev_data[31:0] = 32'hFF00FF00;
    chk("t2 be", ret[0].data, ev_data);

    // back-pressure freeze with a fourth read held off
    issue(1'b0, BASE + 32'h200, lanes(32'hA000_0000), '1, 8'h00, gw);
    step(LAT + 1);
    ret.delete();
    fork
      begin
        issue(1'b1, BASE + 32'h200, '0, '0, 8'h30, g0);
        issue(1'b1, BASE + 32'h204, '0, '0, 8'h31, g1);
        issue(1'b1, BASE + 32'h208, '0, '0, 8'h32, g2);
        issue(1'b1, BASE + 32'h20C, '0, '0, 8'h33, g3);
      end
      begin
        step(3);
        req.lrdy = 1'b0;
        step(4);
        req.lrdy = 1'b1;
      end
    join
    wait_ret(4);
    for (int j = 0; j < 4; j++) begin
      chk("t3 order", DATA_W'(ret[j].user), DATA_W'(8'h30 + j));
      chk("t3 lane0", DATA_W'(ret[j].data[31:0]), DATA_W'(32'hA000_0000 + j));
    end
`ifndef REDMULE_TCDM_RESP_STALL_EN
    chk("t3 held gnt", DATA_W'(g3 - g0), DATA_W'(7));
    chk("t3 ret0", DATA_W'(ret[0].c - g0), DATA_W'(7));
    chk("t3 ret3", DATA_W'(ret[3].c - g0), DATA_W'(10));
`endif

    // wrap at the top of memory
    ret.delete();
    issue(1'b0, BASE + 4*(NW-2), lanes(32'hB000_0000), '1, 8'h00, gw);
    issue(1'b1, BASE + 4*(NW-2), '0, '0, 8'h40, gr);
    issue(1'b1, BASE, '0, '0, 8'h41, gr);
    wait_ret(2);
    chk("t4 wrap", ret[0].data, lanes(32'hB000_0000));
    chk("t4 word0", DATA_W'(ret[1].data[31:0]), DATA_W'(32'hB000_0002));

    // out of range reads and dropped writes
    ret.delete();
    issue(1'b1, BASE + 4*NW, '0, '0, 8'h50, gr);
    issue(1'b1, BASE - 4, '0, '0, 8'h51, gr);
    issue(1'b0, BASE + 4*NW, '1, '1, 8'h00, gw);
    issue(1'b0, BASE - 4, '1, '1, 8'h00, gw);
    issue(1'b1, BASE, '0, '0, 8'h52, gr);
    wait_ret(3);
    chk("t5 oor data", ret[0].data, '0);
    chk("t5 oor opc", DATA_W'(ret[0].opc), DATA_W'(1));
    chk("t5 low opc", DATA_W'(ret[1].opc), DATA_W'(1));
    chk("t5 no write", DATA_W'(ret[2].data[31:0]), DATA_W'(32'hB000_0002));
    chk("t5 in opc", DATA_W'(ret[2].opc), '0);

    // clear discards same-cycle and in-flight reads
    ret.delete();
    clear = 1'b1;
    issue(1'b1, BASE, '0, '0, 8'h60, gr);
    clear = 1'b0;
    issue(1'b1, BASE, '0, '0, 8'h61, gr);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(8);
    chk("clear drops", DATA_W'(ret.size()), '0);
    issue(1'b1, BASE, '0, '0, 8'h62, gr);
    wait_ret(1);
    chk("after clear", DATA_W'(ret[0].user), DATA_W'(8'h62));

    // sustained burst
    ret.delete();
    k = 0;
    n = 0;
    stalls = 0;
    req.req = 1'b1;
    req.wen = 1'b1;
    while (k < NBURST && n < NBURST * 4) begin
      req.add = BASE + 32'h100 + 4 * (k % 4);
      req.user = USER_W'(k);
`ifndef REDMULE_TCDM_RESP_STALL_EN
      req.lrdy = (cyc % 7) != 3;
`endif
      @(negedge clk);
      if (rsp.gnt) k++;
      else stalls++;
      step(1);
      n++;
    end
    req.req = 1'b0;
    req.lrdy = 1'b1;
    chk("burst grants", DATA_W'(k), DATA_W'(NBURST));
    wait_ret(NBURST);
    errs = 0;
    foreach (ret[j]) if (ret[j].user != USER_W'(j)) errs++;
    chk("burst order", DATA_W'(errs), '0);
`ifdef REDMULE_TCDM_RESP_STALL_EN
    chk("stall rate", DATA_W'(stalls >= 200 && stalls <= 450), DATA_W'(1));
`endif

    // reset mid-burst drops in-flight reads
    req.req = 1'b1;
    req.wen = 1'b1;
    req.add = BASE + 32'h100;
    k = 0;
    n = 0;
    while (k < 20 && n < 100) begin
      @(negedge clk);
      if (rsp.gnt) k++;
      step(1);
      n++;
    end
    req.req = 1'b0;
    rst_ni = 1'b0;
    snap = rv_cnt;
    step(2);
    rst_ni = 1'b1;
    step(10);
    chk("no r_valid after rst", DATA_W'(rv_cnt - snap), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
